// File: rtl/fetch_pkg.sv
// Shared fetch-unit constants: widths, reset vector, filler NOP and address-region decode.
package fetch_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  localparam logic [3:0] REGION_BIOS = 4'h4;
  localparam logic [3:0] REGION_IMEM = 4'h1;

  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_BIOS,
    RGN_IMEM
  } region_t;

  function automatic region_t region_of(input logic [3:0] top_bits);
    case (top_bits)
      REGION_BIOS: return RGN_BIOS;
      REGION_IMEM: return RGN_IMEM;
      default:     return RGN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; flush (and rst) override push/pop in the same cycle.
// Head is presented combinationally from storage; callers must not pop when empty.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, one sync-read request per cycle to BIOS/IMEM, flushable queue to decode.
// Requests are credited so queue entries plus the in-flight response never exceed FQ_DEPTH.
module fetch_unit #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] NOP      = fetch_pkg::NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_en,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] imem_dout,
  input  logic [XLEN-1:0] bios_dout,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  import fetch_pkg::*;

  localparam int AW = $clog2(FQ_DEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   rsp_pc;
  logic [XLEN-1:0]   rsp_data;
  region_t           rsp_sel;
  logic              inflight;
  logic              issue;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              q_full;
  logic [AW:0]       q_count;
  logic [AW+1:0]     occ;
  logic [2*XLEN-1:0] q_dout;

  assign addr = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : fetch_pc;
  assign occ  = {1'b0, q_count} + {{(AW + 1){1'b0}}, inflight};

  // A redirect both blocks the pop and discards the response landing this cycle.
  assign pop   = !q_empty && instr_ready && !redirect_valid;
  assign issue = !rst && (redirect_valid || (occ < (AW + 2)'(FQ_DEPTH)) || pop);
  assign push  = inflight && !redirect_valid && (!q_full || pop);

  always_comb begin
    rsp_data = NOP;
    case (rsp_sel)
      RGN_BIOS: rsp_data = bios_dout;
      RGN_IMEM: rsp_data = imem_dout;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      rsp_sel  <= RGN_NONE;
      rsp_pc   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= addr + XLEN'(4);
        rsp_sel  <= region_of(addr[XLEN-1:XLEN-4]);
        rsp_pc   <= addr;
      end
    end
  end

  fetch_queue #(
    .WIDTH (2 * XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({rsp_pc, rsp_data}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign mem_en      = issue;
  assign mem_addr    = rst ? RESET_PC : addr;
  assign instr_valid = !q_empty;
  assign instr       = q_empty ? '0 : q_dout[XLEN-1:0];
  assign instr_pc    = q_empty ? '0 : q_dout[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: three fetch units (FQ_DEPTH 2/4/8) share stimulus; BIOS returns address, IMEM returns ~address.
module tb_fetch_unit;

  localparam int ND = 3;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;

  logic        men   [ND];
  logic [31:0] maddr [ND];
  logic [31:0] bios_d[ND];
  logic [31:0] imem_d[ND];
  logic        ival  [ND];
  logic [31:0] iins  [ND];
  logic [31:0] ipc   [ND];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    fetch_unit #(.FQ_DEPTH(2 << g)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_en         (men[g]),
      .mem_addr       (maddr[g]),
      .imem_dout      (imem_d[g]),
      .bios_dout      (bios_d[g]),
      .instr_valid    (ival[g]),
      .instr          (iins[g]),
      .instr_pc       (ipc[g]),
      .instr_ready    (instr_ready)
    );

    always @(posedge clk) begin
      if (men[g]) begin
        bios_d[g] <= maddr[g];
        imem_d[g] <= ~maddr[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("%s valid d%0d", tag, 2 << g), 32'(ival[g]), 32'd1);
      chk($sformatf("%s pc d%0d", tag, 2 << g), ipc[g], pc);
      chk($sformatf("%s instr d%0d", tag, 2 << g), iins[g], ins);
    end
  endtask

  task automatic expect_empty(input string tag);
    for (int g = 0; g < ND; g++)
      chk($sformatf("%s valid d%0d", tag, 2 << g), 32'(ival[g]), 32'd0);
  endtask

  task automatic expect_req(input string tag, input logic en, input logic [31:0] a);
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("%s mem_en d%0d", tag, 2 << g), 32'(men[g]), 32'(en));
      chk($sformatf("%s mem_addr d%0d", tag, 2 << g), maddr[g], a);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    repeat (3) next();
    settle();
    expect_req("reset", 1'b0, 32'h4000_0000);
    expect_empty("reset");
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("reset instr d%0d", 2 << g), iins[g], 32'h0);
      chk($sformatf("reset instr_pc d%0d", 2 << g), ipc[g], 32'h0);
    end

    // Cycle r: first request; head appears at r+2.
    next(); rst = 1'b0; settle();
    expect_req("first_req", 1'b1, 32'h4000_0000);
    next(); settle();
    expect_empty("r_plus_1");
    next(); settle();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin next(); settle(); end
      expect_head("stream", 32'h4000_0000 + 32'(4 * k), 32'h4000_0000 + 32'(4 * k));
    end

    // Stall for 10 cycles: head frozen at 0x18, queue fills, requests stop.
    next(); instr_ready = 1'b0; settle();
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin next(); settle(); end
      expect_head("stall", 32'h4000_0018, 32'h4000_0018);
    end
    for (int g = 0; g < ND; g++)
      chk($sformatf("stall full mem_en d%0d", 2 << g), 32'(men[g]), 32'd0);

    // Release: next request follows exactly DEPTH buffered entries, stream continues gap-free.
    next(); instr_ready = 1'b1; settle();
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("release mem_en d%0d", 2 << g), 32'(men[g]), 32'd1);
      chk($sformatf("release mem_addr d%0d", 2 << g), maddr[g], 32'h4000_0018 + 32'(4 * (2 << g)));
    end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin next(); settle(); end
      expect_head("drain", 32'h4000_0018 + 32'(4 * k), 32'h4000_0018 + 32'(4 * k));
    end

    // Two stall cycles build up the queue, then redirect into IMEM (low bits ignored).
    next(); instr_ready = 1'b0; settle();
    next(); settle();
    next(); redirect_valid = 1'b1; redirect_pc = 32'h1000_0102; settle();
    expect_req("redir_imem req", 1'b1, 32'h1000_0100);
    expect_head("redir_imem hold", 32'h4000_0048, 32'h4000_0048);
    next(); redirect_valid = 1'b0; instr_ready = 1'b1; settle();
    expect_empty("redir_imem bubble");
    next(); settle();
    expect_head("redir_imem tgt", 32'h1000_0100, 32'hEFFF_FEFF);
    next(); settle();
    expect_head("redir_imem tgt+4", 32'h1000_0104, 32'hEFFF_FEFB);

    // Unmapped region returns NOP.
    next(); redirect_valid = 1'b1; redirect_pc = 32'h2000_0000; settle();
    next(); redirect_valid = 1'b0; settle();
    expect_empty("redir_nop bubble");
    next(); settle();
    expect_head("redir_nop tgt", 32'h2000_0000, 32'h0000_0013);
    next(); settle();
    expect_head("redir_nop tgt+4", 32'h2000_0004, 32'h0000_0013);

    // Back-to-back redirects: A is squashed, only B onward appears.
    next(); redirect_valid = 1'b1; redirect_pc = 32'h1000_0200; settle();
    next(); redirect_pc = 32'h4000_1000; settle();
    expect_empty("b2b t+1");
    expect_req("b2b reqB", 1'b1, 32'h4000_1000);
    next(); redirect_valid = 1'b0; settle();
    expect_empty("b2b t+2");
    for (int k = 0; k < 3; k++) begin
      next(); settle();
      expect_head("b2b B", 32'h4000_1000 + 32'(4 * k), 32'h4000_1000 + 32'(4 * k));
    end

    // Reset while stalled with a response in flight.
    next(); instr_ready = 1'b0; settle();
    next(); settle();
    next(); rst = 1'b1; settle();
    expect_req("rst_mid req", 1'b0, 32'h4000_0000);
    next(); settle();
    expect_empty("rst_mid after");
    expect_req("rst_mid after", 1'b0, 32'h4000_0000);
    for (int g = 0; g < ND; g++)
      chk($sformatf("rst_mid instr_pc d%0d", 2 << g), ipc[g], 32'h0);
    next(); rst = 1'b0; instr_ready = 1'b1; settle();
    expect_req("restart req", 1'b1, 32'h4000_0000);
    next(); settle();
    expect_empty("restart r+1");
    next(); settle();
    expect_head("restart r+2", 32'h4000_0000, 32'h4000_0000);
    next(); settle();
    expect_head("restart r+3", 32'h4000_0004, 32'h4000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
